// File: rtl/ccu_pkg.sv
// Shared definitions for the count packetizer: state encoding, default header, frame sizing.
package ccu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

    localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

    function automatic int bytes_per_frame(input int count_width, input int num_channels);
        return (count_width / 8) * num_channels;
    endfunction

endpackage

// File: rtl/frame_byte_sel.sv
// Combinational byte picker: maps a frame byte index onto the snapshot, MS byte first per channel.
module frame_byte_sel #(
    parameter int COUNT_WIDTH  = 32,
    parameter int NUM_CHANNELS = 4,
    parameter int IDX_W        = 4
) (
    input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] snap_i,
    input  logic [IDX_W-1:0]                    idx_i,
    output logic [7:0]                          byte_o
);

    localparam int BPC = COUNT_WIDTH / 8;
    localparam int BPF = BPC * NUM_CHANNELS;

    always_comb begin
        byte_o = 8'h00;
        for (int j = 0; j < BPF; j++) begin
            if (idx_i == IDX_W'(j)) begin
                byte_o = snap_i[(j / BPC) * COUNT_WIDTH + (BPC - 1 - (j % BPC)) * 8 +: 8];
            end
        end
    end

endmodule

// File: rtl/count_packetizer.sv
// Snapshots a coincidence-count frame and streams it as header + MS-first count bytes.
// Define CHECKSUM_EN to append an XOR-of-data-bytes trailer byte to every frame.
module count_packetizer
    import ccu_pkg::*;
#(
    parameter int          COUNT_WIDTH  = 32,
    parameter int          NUM_CHANNELS = 4,
    parameter logic [7:0]  HEADER_BYTE  = HEADER_BYTE_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                count_valid,
    input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] count_data,
    output logic                                count_ready,
    output logic [7:0]                          tx_data,
    output logic                                tx_valid,
    input  logic                                tx_ready,
    output logic                                frame_busy,
    output logic [7:0]                          drop_cnt
);

    localparam int BPF   = bytes_per_frame(COUNT_WIDTH, NUM_CHANNELS);
    localparam int IDX_W = (BPF > 1) ? $clog2(BPF) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPF - 1);

    state_t                              state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [NUM_CHANNELS*COUNT_WIDTH-1:0] snap_q;
    logic [7:0]                          drop_q;
    logic [7:0]                          sel_byte;
    logic                                accept;
    logic                                xfer;

    assign accept      = count_valid && (state_q == ST_IDLE);
    assign xfer        = tx_valid && tx_ready;
    assign count_ready = (state_q == ST_IDLE);
    assign tx_valid    = (state_q != ST_IDLE);
    assign frame_busy  = (state_q != ST_IDLE);
    assign drop_cnt    = drop_q;

    frame_byte_sel #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .NUM_CHANNELS(NUM_CHANNELS),
        .IDX_W       (IDX_W)
    ) u_sel (
        .snap_i(snap_q),
        .idx_i (idx_q),
        .byte_o(sel_byte)
    );

`ifdef CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 8'h00;
        end else if (accept) begin
            csum_q <= 8'h00;
        end else if (state_q == ST_DATA && xfer) begin
            csum_q <= csum_q ^ sel_byte;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            drop_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (count_valid && !count_ready && drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    // Snapshot is pure data; it is only meaningful once a frame has been accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            snap_q <= count_data;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tx_data = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (count_valid) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                tx_data = HEADER_BYTE;
                if (tx_ready) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                tx_data = sel_byte;
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
`ifdef CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
`ifdef CHECKSUM_EN
                tx_data = csum_q;
`endif
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_count_packetizer.sv
// Randomized self-checking bench for count_packetizer (COUNT_WIDTH=32, NUM_CHANNELS=2).
module tb_count_packetizer;

    localparam int CW = 32;
    localparam int NC = 2;
    localparam int DW = CW * NC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          count_valid = 1'b0;
    logic [DW-1:0] count_data = '0;
    logic          count_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          frame_busy;
    logic [7:0]    drop_cnt;

    int errors = 0;
    int checks = 0;
    int drops_exp = 0;
    logic [7:0] exp_q[$];

    count_packetizer #(
        .COUNT_WIDTH (CW),
        .NUM_CHANNELS(NC),
        .HEADER_BYTE (8'hA5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_valid(count_valid),
        .count_data (count_data),
        .count_ready(count_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .frame_busy (frame_busy),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference frame: header, each channel in order with its bytes MS first, optional XOR trailer.
    task automatic build_expected(input logic [DW-1:0] data);
        logic [CW-1:0] chan;
        logic [7:0]    x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        x = 8'h00;
        for (int ch = 0; ch < NC; ch++) begin
            chan = data[ch*CW +: CW];
            for (int b = 0; b < CW / 8; b++) begin
                exp_q.push_back(chan[CW-1:CW-8]);
                x = x ^ chan[CW-1:CW-8];
                chan = chan << 8;
            end
        end
`ifdef CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic start_frame(input logic [DW-1:0] data);
        int k = 0;
        while (!count_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("ready_wait", 32'(count_ready), 32'd1);
        count_valid = 1'b1;
        count_data  = data;
        build_expected(data);
        @(negedge clk);
        count_valid = 1'b0;
        check_eq("accept_busy", 32'(frame_busy), 32'd1);
    endtask

    // mode 0: always ready, 1: ready one cycle in three, 2: random ready.
    task automatic drain(input int mode, input bit scramble, input int limit);
        int   n = 0;
        bit   stalled = 1'b0;
        bit   rdy;
        logic [7:0] held = 8'h00;
        for (int cyc = 0; cyc < 400 && n < limit; cyc++) begin
            if (stalled) begin
                check_eq("hold_valid", 32'(tx_valid), 32'd1);
                check_eq("hold_data", 32'(tx_data), 32'(held));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 2);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            tx_ready = rdy;
            if (mode == 0) check_eq("contiguous", 32'(tx_valid), 32'd1);
            if (tx_valid && rdy) begin
                check_eq($sformatf("byte%0d", n), 32'(tx_data), 32'(exp_q[n]));
                n++;
                stalled = 1'b0;
            end else if (tx_valid) begin
                stalled = 1'b1;
                held = tx_data;
            end
            if (scramble) count_data = {$urandom, $urandom};
            @(negedge clk);
        end
        check_eq("frame_len", 32'(n), 32'(limit));
        tx_ready = 1'b0;
        if (limit == exp_q.size()) begin
            check_eq("end_valid", 32'(tx_valid), 32'd0);
            check_eq("end_busy", 32'(frame_busy), 32'd0);
            check_eq("end_ready", 32'(count_ready), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        @(negedge clk);
        check_eq("rst_ready", 32'(count_ready), 32'd1);
        check_eq("rst_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_data", 32'(tx_data), 32'd0);
        check_eq("rst_busy", 32'(frame_busy), 32'd0);
        check_eq("rst_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-rate frame, then the same frame under a 1-in-3 ready pattern.
        start_frame({32'h0000_0102, 32'hDEAD_BEEF});
        drain(0, 1'b0, exp_q.size());
        start_frame({32'h0000_0102, 32'hDEAD_BEEF});
        drain(1, 1'b0, exp_q.size());

        // Checksum-sensitive pattern, then input churn while the frame is in flight.
        start_frame({32'h0000_0000, 32'h0102_0304});
        drain(0, 1'b0, exp_q.size());
        start_frame({32'h1234_5678, 32'h9ABC_DEF0});
        drain(2, 1'b1, exp_q.size());

        for (int r = 0; r < 6; r++) begin
            d = {$urandom, $urandom};
            start_frame(d);
            drain(r % 3, (r % 2) == 1, exp_q.size());
        end

        // Snapshots offered while busy are dropped and counted, saturating.
        d = {$urandom, $urandom};
        start_frame(d);
        tx_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            count_valid = 1'b1;
            count_data  = {$urandom, $urandom};
            @(negedge clk);
            drops_exp = (drops_exp < 255) ? drops_exp + 1 : 255;
            if (i == 9) check_eq("drop_10", 32'(drop_cnt), 32'(drops_exp));
        end
        count_valid = 1'b0;
        check_eq("drop_sat", 32'(drop_cnt), 32'h0000_00FF);
        check_eq("drop_hdr", 32'(tx_data), 32'h0000_00A5);
        drain(0, 1'b0, exp_q.size());
        check_eq("drop_hold", 32'(drop_cnt), 32'h0000_00FF);

        // Asynchronous reset mid-frame abandons it and clears the drop counter.
        start_frame({32'h0000_0102, 32'hDEAD_BEEF});
        drain(0, 1'b0, 3);
        #2 rst_n = 1'b0;
        #1;
        drops_exp = 0;
        check_eq("midrst_valid", 32'(tx_valid), 32'd0);
        check_eq("midrst_data", 32'(tx_data), 32'd0);
        check_eq("midrst_drop", 32'(drop_cnt), 32'(drops_exp));
        check_eq("midrst_busy", 32'(frame_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        d = {$urandom, $urandom};
        start_frame(d);
        drain(0, 1'b0, exp_q.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
